// File: rtl/nn_l1_pkg.sv
// nn_l1_pkg: shared constants, FSM state encoding and sign-extension helper
// for the layer-1 neuron accumulate/activate stage.
package nn_l1_pkg;

    localparam int LANES = 28;
    localparam int IN_W  = 18;
    localparam int ACC_W = 24;
    localparam int OUT_W = 8;
    localparam int CNT_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2,
        OUT  = 2'd3
    } state_t;

    function automatic logic signed [ACC_W-1:0] sext_in(input logic [IN_W-1:0] x);
        return {{(ACC_W-IN_W){x[IN_W-1]}}, x};
    endfunction

endpackage

// File: rtl/neuron_accum_act_if.sv
// neuron_accum_act_if: lane-bank input handshake and activation output
// handshake of the neuron accumulate/activate stage.
//   in_valid/in_ready/mac_in/bias : lane bank from the MAC array
//   out_valid/out_ready/out_data  : activation towards the layer-2 buffer
//   busy                          : stage is accumulating or finishing
// Modports: slave = the stage itself, master = the environment driving it.
interface neuron_accum_act_if;
    import nn_l1_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*IN_W-1:0] mac_in;
    logic [IN_W-1:0]       bias;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic                  busy;

    modport slave (
        input  in_valid, mac_in, bias, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, mac_in, bias, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/neuron_accum_act_act_sat.sv
// act_sat: combinational activation with saturation, ACC_W -> OUT_W.
//   sum : signed accumulated value (lanes + bias)
//   act : activation result
// Build option NEURON_RELU_EN:
//   defined   -> ReLU clipped to 0..2^OUT_W-1, unsigned result
//   undefined -> signed clamp to -2^(OUT_W-1)..2^(OUT_W-1)-1, two's complement
module act_sat
    import nn_l1_pkg::*;
(
    input  logic signed [ACC_W-1:0] sum,
    output logic [OUT_W-1:0]        act
);

`ifdef NEURON_RELU_EN
    localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((1 << OUT_W) - 1);

    always_comb begin
        act = sum[OUT_W-1:0];
        if (sum < 0) begin
            act = '0;
        end else if (sum > U_MAX) begin
            act = '1;
        end
    end
`else
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
    // bitwise complement of 2^(n-1)-1 is -2^(n-1)
    localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

    always_comb begin
        act = sum[OUT_W-1:0];
        if (sum > S_MAX) begin
            act = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (sum < S_MIN) begin
            act = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end
`endif

endmodule

// File: rtl/neuron_accum_act.sv
// neuron_accum_act: captures one bank of LANES signed MAC results plus bias,
// reduces the lanes sequentially into a signed ACC_W sum, adds the bias,
// applies the activation (act_sat, NEURON_RELU_EN selects ReLU) and offers the
// result over a valid/ready handshake.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : neuron_accum_act_if.slave (lane bank in, activation out, busy)
//
// state | meaning
// IDLE  | in_ready high, waiting for a lane bank
// ACC   | adding lane[cnt] to acc, one lane per cycle
// FIN   | adding bias, registering the activation
// OUT   | holding out_valid/out_data until out_ready
module neuron_accum_act
    import nn_l1_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    neuron_accum_act_if.slave         bus
);

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic [LANES*IN_W-1:0]    mac_q, mac_d;
    logic [IN_W-1:0]          bias_q, bias_d;

    logic [IN_W-1:0]          lane_sel;
    logic signed [ACC_W-1:0]  sum_w;
    logic [OUT_W-1:0]         act_w;

    assign lane_sel = mac_q[int'(cnt_q)*IN_W +: IN_W];
    assign sum_w    = acc_q + sext_in(bias_q);

    act_sat u_act_sat (
        .sum (sum_w),
        .act (act_w)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mac_d       = mac_q;
        bias_d      = bias_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mac_d   = bus.mac_in;
                    bias_d  = bus.bias;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d = acc_q + sext_in(lane_sel);
                if (cnt_q == CNT_W'(LANES-1)) begin
                    cnt_d   = '0;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN: begin
                out_data_d  = act_w;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // lane bank is only read after a capture, so it needs no reset
    always_ff @(posedge clk) begin
        mac_q  <= mac_d;
        bias_q <= bias_d;
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == ACC) || (state_q == FIN);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_accum_act.sv
module tb_neuron_accum_act;
    import nn_l1_pkg::*;

    localparam int W = LANES*IN_W;

`ifdef NEURON_RELU_EN
    localparam int EXP_FULL = 255;
    localparam int EXP_NEG  = 0;
`else
    localparam int EXP_FULL = 127;
    localparam int EXP_NEG  = 128;   // 8'h80 = -128
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    neuron_accum_act_if bus();

    neuron_accum_act dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int bank_sum(input logic [W-1:0] m, input logic [IN_W-1:0] b);
        int s;
        logic signed [IN_W-1:0] l;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            l = m[i*IN_W +: IN_W];
            s += l;
        end
        l = b;
        s += l;
        return s;
    endfunction

    function automatic logic [7:0] act_ref(input int s);
`ifdef NEURON_RELU_EN
        if (s < 0)   return 8'd0;
        if (s > 255) return 8'd255;
        return s[7:0];
`else
        if (s > 127)  return 8'd127;
        if (s < -128) return 8'h80;
        return s[7:0];
`endif
    endfunction

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0]    r;
        logic [IN_W-1:0] t;
        t = IN_W'(v);
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = t;
        return r;
    endfunction

    // Transaction-level timing model: a capture in idle produces its result
    // 29 edges later; the result is held until accepted, after which the
    // block is idle again.
    int         cyc = 0;
    bit         m_idle = 1'b1;
    bit         m_valid = 1'b0;
    logic [7:0] m_data = '0;
    logic [7:0] m_pend = '0;
    int         due = 0;
    int         cap_log[$];
    logic [7:0] hs_log[$];
    int         rise_cyc = 0;
    logic       prev_ov = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_idle  = 1'b1;
            m_valid = 1'b0;
        end else if (m_idle && bus.in_valid) begin
            m_pend = act_ref(bank_sum(bus.mac_in, bus.bias));
            m_idle = 1'b0;
            due    = cyc + 29;
            cap_log.push_back(cyc);
        end else if (m_valid && bus.out_ready) begin
            hs_log.push_back(bus.out_data);
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end else if (!m_idle && !m_valid && cyc == due) begin
            m_valid = 1'b1;
            m_data  = m_pend;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("out_valid", int'(bus.out_valid), int'(m_valid));
            chk("in_ready", int'(bus.in_ready), int'(m_idle));
            chk("busy", int'(bus.busy), int'(!m_idle && !m_valid));
            if (m_valid) chk("out_data", int'(bus.out_data), int'(m_data));
            if (bus.out_valid && !prev_ov) rise_cyc = cyc - 1;
            prev_ov = bus.out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [W-1:0] m, input logic [IN_W-1:0] b);
        int k = 0;
        bus.mac_in   = m;
        bus.bias     = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("send_timeout", k, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mac_in   = ~m;       // post-capture changes must not matter
        bus.bias     = ~b;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("valid_timeout", k, 0);
    endtask

    logic [W-1:0] v;
    int           c0;

    initial begin
        bus.in_valid  = 1'b0;
        bus.mac_in    = '0;
        bus.bias      = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        reset = 1'b1;
        @(negedge clk);

        // all lanes 1, bias 0
        bus.out_ready = 1'b1;
        send(fill(1), 18'd0);
        wait_valid();
        @(negedge clk);
        chk("t1_latency", rise_cyc - cap_log[$], 29);
        chk("t1_data", int'(hs_log[$]), 28);

        // full scale lanes and bias, no wrap
        v = fill(131071);
        chk("t2_model_sum", bank_sum(v, 18'h1FFFF), 3801059);
        send(v, 18'h1FFFF);
        wait_valid();
        @(negedge clk);
        chk("t2_data", int'(hs_log[$]), EXP_FULL);

        // alternating -1000/+900, bias -50
        for (int i = 0; i < LANES; i++)
            v[i*IN_W +: IN_W] = (i % 2 == 0) ? IN_W'(-1000) : IN_W'(900);
        chk("t3_model_sum", bank_sum(v, IN_W'(-50)), -1450);
        send(v, IN_W'(-50));
        wait_valid();
        @(negedge clk);
        chk("t3_data", int'(hs_log[$]), EXP_NEG);

        // consumer stalls 10 cycles in OUT, in_valid pulses ignored
        bus.out_ready = 1'b0;
        send(fill(3), 18'd10);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.mac_in   = fill(7);
            bus.bias     = 18'd0;
            chk("t4_hold_data", int'(bus.out_data), 94);
            chk("t4_hold_valid", int'(bus.out_valid), 1);
            chk("t4_in_ready", int'(bus.in_ready), 0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t4_valid_drop", int'(bus.out_valid), 0);
        chk("t4_ready_back", int'(bus.in_ready), 1);
        chk("t4_hs_count_data", int'(hs_log[$]), 94);
        c0 = hs_log.size();
        repeat (3) @(negedge clk);
        chk("t4_single_hs", hs_log.size(), c0);

        // reset during ACC cycle 14, then a fresh bank of 2s
        send(fill(5), 18'd0);
        repeat (13) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t5_valid", int'(bus.out_valid), 0);
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_in_ready", int'(bus.in_ready), 1);
        chk("t5_out_data", int'(bus.out_data), 0);
        send(fill(2), 18'd0);
        wait_valid();
        @(negedge clk);
        chk("t5_data", int'(hs_log[$]), 56);

        // back-to-back banks with out_ready tied high
        for (int i = 0; i < LANES; i++) v[i*IN_W +: IN_W] = IN_W'(i - 14);
        c0 = hs_log.size();
        send(v, 18'd20);
        send(fill(4), IN_W'(-3));
        chk("t6_period", cap_log[$] - cap_log[$-1], 31);
        wait_valid();
        @(negedge clk);
        chk("t6_count", hs_log.size() - c0, 2);
        if (hs_log.size() - c0 == 2) begin
            chk("t6_first", int'(hs_log[c0]), 6);
            chk("t6_second", int'(hs_log[c0+1]), 109);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
